// File: rtl/gray_stream_decoder_if.sv
// gray_stream_decoder_if
//   Handshake bundle for the Gray stream decoder.
//   Input side:  in_valid / in_ready / in_gray  (producer -> decoder)
//   Output side: out_valid / out_ready / out_bin (decoder -> consumer)
//   step_err:    single-step violation flag, meaningful while out_valid=1
//   Modports: master = producer/consumer side (testbench), slave = decoder.
interface gray_stream_decoder_if #(
   parameter int WIDTH = 3
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_gray;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_bin;
   logic             step_err;

   modport master (
      output in_valid, in_gray, out_ready,
      input  in_ready, out_valid, out_bin, step_err
   );

   modport slave (
      input  in_valid, in_gray, out_ready,
      output in_ready, out_valid, out_bin, step_err
   );
endinterface

// File: rtl/gray_stream_decoder.sv
// gray_stream_decoder
//   Accepts one Gray-coded word, converts it to binary one bit per clock
//   (MSB first), then presents the result until the consumer takes it.
//   Optional macro: GRAY_STEP_CHECK_EN -- when defined, step_err flags any
//   accepted word whose Hamming distance from the previously accepted word
//   is not exactly 1. When undefined, step_err is tied low.
//   Ports:
//     clk    - clock, rising edge
//     reset  - asynchronous active-high reset
//     bus    - gray_stream_decoder_if.slave (in_valid/in_ready/in_gray,
//              out_valid/out_ready/out_bin, step_err)
//
//   state  | meaning
//   IDLE   | ready for a new word (in_ready=1)
//   DECODE | resolving one binary bit per cycle, MSB first
//   DONE   | out_bin/out_valid presented until out_ready
module gray_stream_decoder #(
   parameter int WIDTH = 3
) (
   input logic                  clk,
   input logic                  reset,
   gray_stream_decoder_if.slave bus
);
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DECODE = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [IW-1:0]    idx;
   logic [WIDTH-1:0] g_reg;
   logic [WIDTH-1:0] work;
   logic [WIDTH-1:0] out_bin_q;
   logic             prev_bit;
   logic             bit_new;
   logic             accept;
   logic             in_ready_c;
   logic             out_valid_c;

   assign accept  = (state == IDLE) && bus.in_valid;
   // prev_bit carries bin[idx+1]; it starts at 0 so the MSB equals g[MSB]
   assign bit_new = prev_bit ^ g_reg[idx];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      case (state)
         IDLE: begin
            in_ready_c = 1'b1;
            if (bus.in_valid) state_nxt = DECODE;
         end
         DECODE: begin
            if (idx == '0) state_nxt = DONE;
         end
         DONE: begin
            out_valid_c = 1'b1;
            if (bus.out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx       <= '0;
         g_reg     <= '0;
         work      <= '0;
         prev_bit  <= 1'b0;
         out_bin_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  g_reg    <= bus.in_gray;
                  idx      <= IW'(WIDTH - 1);
                  prev_bit <= 1'b0;
                  work     <= '0;
               end
            end
            DECODE: begin
               work[idx] <= bit_new;
               prev_bit  <= bit_new;
               if (idx == '0) begin
                  // work[0] is not yet written, so splice the fresh LSB in
                  out_bin_q <= {work[WIDTH-1:1], bit_new};
               end else begin
                  idx <= idx - IW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.out_bin   = out_bin_q;

`ifdef GRAY_STEP_CHECK_EN
   logic [WIDTH-1:0] hist;
   logic             hist_valid;
   logic             step_flag;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hist       <= '0;
         hist_valid <= 1'b0;
         step_flag  <= 1'b0;
      end else if (accept) begin
         hist       <= bus.in_gray;
         hist_valid <= 1'b1;
         step_flag  <= hist_valid && ($countones(hist ^ bus.in_gray) != 1);
      end
   end

   assign bus.step_err = out_valid_c & step_flag;
`else
   assign bus.step_err = 1'b0;
`endif
endmodule

// File: tb/tb_gray_stream_decoder.sv
module tb_gray_stream_decoder;
   localparam int W = 3;

   logic clk;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   gray_stream_decoder_if #(.WIDTH(W)) bus ();

   gray_stream_decoder #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef GRAY_STEP_CHECK_EN
   localparam logic STEP_ON = 1'b1;
`else
   localparam logic STEP_ON = 1'b0;
`endif

   // Prefix-XOR reference: bin = g ^ g>>1 ^ g>>2 ...
   function automatic logic [W-1:0] ref_bin(input logic [W-1:0] g);
      logic [W-1:0] b;
      b = '0;
      for (int s = 0; s < W; s++) b = b ^ (g >> s);
      return b;
   endfunction

   // Called right after a negedge with the DUT idle. Returns the decoded word,
   // step_err while presented, and the number of negedges from drive to out_valid.
   task automatic send_word(input logic [W-1:0] g, output logic [W-1:0] b,
                            output logic se, output int lat);
      bus.in_valid = 1'b1;
      bus.in_gray  = g;
      @(negedge clk);
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      b  = bus.out_bin;
      se = bus.step_err;
      if (bus.out_ready) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_gray   = '0;
      bus.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
      checks++; if (bus.out_bin !== 3'b000) begin errors++; $display("FAIL reset_out_bin got %b exp 000", bus.out_bin); end
      checks++; if (bus.step_err !== 1'b0) begin errors++; $display("FAIL reset_step_err got %b exp 0", bus.step_err); end
      reset = 1'b0;
   endtask

   task automatic test_single();
      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_gray   = 3'b110;
      @(negedge clk);
      bus.in_valid = 1'b0;
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL single_busy got %b exp 0", bus.in_ready); end
      repeat (2) @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b exp 0", bus.out_valid); end
      checks++; if (bus.out_bin !== 3'b000) begin errors++; $display("FAIL single_early_bin got %b exp 000", bus.out_bin); end
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", bus.out_valid); end
      checks++; if (bus.out_bin !== 3'b100) begin errors++; $display("FAIL single_bin got %b exp 100", bus.out_bin); end
      @(negedge clk);
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL single_back_idle got %b exp 1", bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop got %b exp 0", bus.out_valid); end
      checks++; if (bus.out_bin !== 3'b100) begin errors++; $display("FAIL single_bin_hold got %b exp 100", bus.out_bin); end
   endtask

   task automatic test_exhaustive();
      logic [W-1:0] g, b, exp_b;
      logic         se;
      int           lat;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         g     = W'(i ^ (i >> 1));
         exp_b = ref_bin(g);
         send_word(g, b, se, lat);
         checks++; if (lat !== 4) begin errors++; $display("FAIL exh_latency g=%b got %0d exp 4", g, lat); end
         checks++; if (b !== exp_b) begin errors++; $display("FAIL exh_ref g=%b got %b exp %b", g, b, exp_b); end
         checks++; if (b !== W'(i)) begin errors++; $display("FAIL exh_order g=%b got %b exp %0d", g, b, i); end
         checks++; if (se !== 1'b0) begin errors++; $display("FAIL exh_step g=%b got %b exp 0", g, se); end
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] b;
      logic         se;
      int           lat;
      bus.out_ready = 1'b0;
      send_word(3'b011, b, se, lat);
      checks++; if (b !== 3'b010) begin errors++; $display("FAIL bp_bin got %b exp 010", b); end
      bus.in_valid = 1'b1;
      bus.in_gray  = 3'b111;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid c=%0d got %b exp 1", c, bus.out_valid); end
         checks++; if (bus.out_bin !== 3'b010) begin errors++; $display("FAIL bp_hold c=%0d got %b exp 010", c, bus.out_bin); end
         checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready c=%0d got %b exp 0", c, bus.in_ready); end
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (2) begin
         @(negedge clk);
         checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_no_accept got %b exp 1", bus.in_ready); end
         checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release got %b exp 0", bus.out_valid); end
      end
   endtask

   task automatic test_reset_mid_decode();
      logic [W-1:0] b;
      logic         se;
      int           lat;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_gray   = 3'b111;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      #1;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", bus.out_valid); end
      checks++; if (bus.out_bin !== 3'b000) begin errors++; $display("FAIL mid_rst_bin got %b exp 000", bus.out_bin); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got %b exp 1", bus.in_ready); end
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_ghost c=%0d got %b exp 0", c, bus.out_valid); end
      end
      send_word(3'b010, b, se, lat);
      checks++; if (b !== 3'b011) begin errors++; $display("FAIL mid_rst_next got %b exp 011", b); end
      checks++; if (se !== 1'b0) begin errors++; $display("FAIL mid_rst_first_step got %b exp 0", se); end
   endtask

   task automatic test_step_check();
      logic [W-1:0] words [4] = '{3'b010, 3'b110, 3'b011, 3'b011};
      logic         exp_se [4];
      logic [W-1:0] b;
      logic         se;
      int           lat;
      exp_se = '{1'b0, 1'b0, STEP_ON, STEP_ON};
      do_reset();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         send_word(words[i], b, se, lat);
         checks++; if (se !== exp_se[i]) begin errors++; $display("FAIL step_err w%0d=%b got %b exp %b", i, words[i], se, exp_se[i]); end
         checks++; if (b !== ref_bin(words[i])) begin errors++; $display("FAIL step_bin w%0d got %b exp %b", i, b, ref_bin(words[i])); end
         checks++; if (bus.step_err !== 1'b0) begin errors++; $display("FAIL step_idle_low w%0d got %b exp 0", i, bus.step_err); end
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] words [5] = '{3'b101, 3'b001, 3'b011, 3'b111, 3'b100};
      logic         was_ready;
      int           cyc, k, got, last_acc;
      do_reset();
      bus.out_ready = 1'b1;
      cyc = 0; k = 0; got = 0; last_acc = -1;
      bus.in_valid = 1'b1;
      bus.in_gray  = words[0];
      while (got < 5 && cyc < 200) begin
         was_ready = bus.in_ready;
         @(negedge clk);
         cyc++;
         if (was_ready && k < 5) begin
            if (last_acc >= 0) begin
               checks++; if (cyc - last_acc !== W + 2) begin errors++; $display("FAIL b2b_interval k=%0d got %0d exp %0d", k, cyc - last_acc, W + 2); end
            end
            last_acc = cyc;
            k++;
            if (k < 5) bus.in_gray = words[k];
            else bus.in_valid = 1'b0;
         end
         if (bus.out_valid) begin
            checks++; if (bus.out_bin !== ref_bin(words[got])) begin errors++; $display("FAIL b2b_word n=%0d got %b exp %b", got, bus.out_bin, ref_bin(words[got])); end
            got++;
         end
      end
      bus.in_valid = 1'b0;
      checks++; if (got !== 5) begin errors++; $display("FAIL b2b_out_count got %0d exp 5", got); end
      checks++; if (k !== 5) begin errors++; $display("FAIL b2b_accept_count got %0d exp 5", k); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_exhaustive();
      test_backpressure();
      test_reset_mid_decode();
      test_step_check();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
